dac_scheduler: RTL and testbench
================================

DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: DAC code width per channel.
REQ-002 SHALL have parameter FRAME_CYCLES, default 64, legal range >= 1: clk cycles reserved per serial DAC frame after each issued word.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en_in  input  1: host write strobe, one word per high cycle.
REQ-006 SHALL have port wr_ch  input  2: host target channel, 0..3.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH: host DAC code.
REQ-008 SHALL have port dac_din  output  16: command word to the serial DAC driver.
REQ-009 SHALL have port dac_wr_en  output  1: one-cycle start strobe to the serial DAC driver.
REQ-010 SHALL have port pending  output  4: per-channel "written, not yet issued" flags.
REQ-011 SHALL have port busy  output  1: high while pending != 0 or state != IDLE.

Function
REQ-012 SHALL hold shadow[0..3]; wr_en_in loads shadow[wr_ch] <= wr_data and sets pending[wr_ch] on the next edge; repeated writes to a pending channel coalesce (last value wins, one issue).
REQ-013 SHALL implement states IDLE, ISSUE, WAIT; IDLE -> ISSUE when pending != 0, selecting sel by round-robin from (last+1) mod 4 upward.
REQ-014 ISSUE (one cycle) SHALL register dac_din = {2'b00, sel[1:0], shadow[sel] zero-extended/left-aligned to 12 bits}, drive dac_wr_en high, clear pending[sel], set last = sel, load counter = FRAME_CYCLES-1, go WAIT.
REQ-015 WAIT SHALL decrement counter each cycle and go IDLE in the cycle counter == 0 (WAIT lasts FRAME_CYCLES cycles).
REQ-016 dac_wr_en SHALL be high exactly one cycle per ISSUE; dac_din SHALL stay stable from ISSUE until the next ISSUE.
REQ-017 Latency: host write at cycle n while IDLE with pending == 0 -> dac_wr_en high at cycle n+2.
REQ-018 Minimum spacing between dac_wr_en pulses SHALL be FRAME_CYCLES+2 cycles.
REQ-019 Host write to channel sel in its ISSUE cycle: issued word uses old shadow; pending[sel] SHALL remain set with the new value (write wins over clear).
REQ-020 Host writes during WAIT SHALL be accepted without stall; no write is ever dropped.
REQ-021 DATA_WIDTH > 12: upper 12 bits of shadow are used; DATA_WIDTH < 12: code left-aligned, LSBs zero.

Reset
REQ-022 rst high SHALL immediately force state IDLE, pending 0, shadow[*] 0, last 3 (ch0 first), counter 0, dac_din 0, dac_wr_en 0, busy 0, ldac 0.
REQ-023 rst asserted mid-WAIT or mid-ISSUE SHALL abort the frame; no dac_wr_en pulse until a new write after rst falls.

Configuration
REQ-024 With macro DAC_SCHEDULER_LDAC_EN defined, the module SHALL add port ldac  output  1, pulsed high for one cycle in the cycle after the final WAIT cycle when pending == 0 and wr_en_in == 0 in that final WAIT cycle.
REQ-025 Without DAC_SCHEDULER_LDAC_EN, port ldac and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-026 FRAME_CYCLES=40: write ch1=0x01B at cycle 10 -> dac_wr_en at 12, dac_din=0x101B, busy low at 53.
REQ-027 Writes ch2=0xAAA, ch0=0x555, ch3=0x0F0 in consecutive cycles -> issue order ch0 (0x0555), ch2 (0x2AAA), ch3 (0x30F0), pulses 42 cycles apart.
REQ-028 Write ch1=0x100 then ch1=0x200 before issue -> single pulse, dac_din=0x1200.
REQ-029 Write ch0=0x123 in ch0 ISSUE cycle of 0x111 -> words 0x0111 then 0x0123, 42 cycles apart.
REQ-030 rst pulse at WAIT counter 20 with ch3 pending -> outputs 0 immediately, no further pulse; with DAC_SCHEDULER_LDAC_EN, ldac pulses once after the last frame of REQ-027 only.

Source files
------------

// File: rtl/dac_scheduler.sv
// -----------------------------------------------------------------------------
// dac_scheduler
//
// Purpose:
//   Collects host writes for four DAC channels into shadow registers and
//   issues them one at a time to a serial DAC driver. Channels are picked
//   round-robin, and each issued word is followed by a fixed frame window.
//   A channel that is written several times before it is issued is sent
//   only once, with the last value written.
//
// Optional feature:
//   DAC_SCHEDULER_LDAC_EN - adds the ldac output. ldac pulses for one cycle
//   after the last frame when nothing is left to send.
//
// Parameters:
//   DATA_WIDTH   - host DAC code width. The word sent uses its upper 12 bits.
//                  Narrower codes are left-aligned and padded with zeros.
//   FRAME_CYCLES - clk cycles reserved after each issued word (>= 1).
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   wr_en_in    in   host write strobe, one word per high cycle
//   wr_ch       in   host target channel 0..3
//   wr_data     in   host DAC code
//   dac_din     out  16-bit command word {2'b00, ch[1:0], code[11:0]}
//   dac_wr_en   out  one-cycle start strobe, high in the ISSUE cycle
//   pending     out  per-channel "written, not yet issued" flags
//   busy        out  high while any channel is pending or the FSM is not idle
//   ldac        out  (DAC_SCHEDULER_LDAC_EN only) load strobe after the last frame
//   o_state_dbg out  current FSM state, for debug and checkers
//
// Handshake: the host side has no ready signal. Every cycle with wr_en_in
// high is accepted. dac_wr_en is a one-cycle strobe. dac_din is valid while
// the strobe is high and holds its value until the next strobe.
// -----------------------------------------------------------------------------
module dac_scheduler #(
    parameter int DATA_WIDTH   = 12,
    parameter int FRAME_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_in,
    input  logic [1:0]            wr_ch,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [15:0]           dac_din,
    output logic                  dac_wr_en,
    output logic [3:0]            pending,
    output logic                  busy,
`ifdef DAC_SCHEDULER_LDAC_EN
    output logic                  ldac,
`endif
    output logic [1:0]            o_state_dbg
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_shadow [4];
    logic [3:0]            r_pending;
    logic [1:0]            r_last;
    logic [CW-1:0]         r_cnt;
    logic [15:0]           r_din;
    logic                  r_wr_en;

    logic                  w_issue;
    logic [1:0]            w_sel;
    logic [1:0]            w_idx;
    logic                  w_found;
    logic [3:0]            w_set;
    logic [3:0]            w_clr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [11:0]           w_sel_code;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != 4'b0000) begin
                    w_state_next = ST_ISSUE;
                    w_issue      = 1'b1;
                end
            end
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Round-robin pick: scan from (last+1) upward, wrapping mod 4.
    always_comb begin
        w_sel   = r_last;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && r_pending[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_data = r_shadow[w_sel];

    generate
        if (DATA_WIDTH >= 12) begin : g_code_wide
            assign w_sel_code = w_sel_data[DATA_WIDTH-1 -: 12];
        end else begin : g_code_narrow
            assign w_sel_code = {w_sel_data, {(12 - DATA_WIDTH){1'b0}}};
        end
    endgenerate

    // The word is latched and the pending flag cleared on the edge that
    // enters ISSUE, so dac_din is valid in the strobe cycle.
    // OR-ing in w_set after the clear means a host write always wins.
    // A write that arrives on this edge or in the ISSUE cycle keeps its
    // channel pending with the new value, so it is never lost.
    assign w_set = wr_en_in ? (4'b0001 << wr_ch) : 4'b0000;
    assign w_clr = w_issue  ? (4'b0001 << w_sel) : 4'b0000;

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
            r_pending <= 4'b0000;
            r_last    <= 2'd3;
            r_cnt     <= '0;
            r_din     <= 16'h0000;
            r_wr_en   <= 1'b0;
        end else begin
            if (wr_en_in) begin
                r_shadow[wr_ch] <= wr_data;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_wr_en   <= w_issue;
            if (w_issue) begin
                r_din  <= {2'b00, w_sel, w_sel_code};
                r_last <= w_sel;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef DAC_SCHEDULER_LDAC_EN
    logic r_ldac;

    // Load the DAC outputs only once nothing else is queued or arriving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ldac <= 1'b0;
        end else begin
            r_ldac <= (r_state == ST_WAIT) && (r_cnt == '0) &&
                      (r_pending == 4'b0000) && !wr_en_in;
        end
    end

    assign ldac = r_ldac;
`endif

    assign dac_din     = r_din;
    assign dac_wr_en   = r_wr_en;
    assign pending     = r_pending;
    assign busy        = (r_pending != 4'b0000) || (r_state != ST_IDLE);
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_dac_scheduler.sv
module tb_dac_scheduler;

  localparam int DW = 12;
  localparam int FC = 40;

  logic          clk;
  logic          rst;
  logic          wr_en_in;
  logic [1:0]    wr_ch;
  logic [DW-1:0] wr_data;
  logic [15:0]   dac_din;
  logic          dac_wr_en;
  logic [3:0]    pending;
  logic          busy;
  logic [1:0]    o_state_dbg;
`ifdef DAC_SCHEDULER_LDAC_EN
  logic          ldac;
  int            ldac_q[$];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [15:0] last_word = 16'h0;
  logic [15:0] mon_w;
  int          mon_c;

  dac_scheduler #(.DATA_WIDTH(DW), .FRAME_CYCLES(FC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_in   (wr_en_in),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .dac_din    (dac_din),
    .dac_wr_en  (dac_wr_en),
    .pending    (pending),
    .busy       (busy),
`ifdef DAC_SCHEDULER_LDAC_EN
    .ldac       (ldac),
`endif
    .o_state_dbg(o_state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // driver tasks
  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_at(input int c, input logic [1:0] ch, input logic [DW-1:0] d);
    goto_cycle(c);
    wr_en_in = 1'b1;
    wr_ch    = ch;
    wr_data  = d;
    goto_cycle(c + 1);
    wr_en_in = 1'b0;
  endtask

  task automatic expect_issue(input logic [15:0] w, input int c);
    exp_q.push_back(w);
    exp_cyc_q.push_back(c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor: samples on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      last_word = 16'h0;
    end else if (dac_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got din=%h at cycle %0d, required no pulse", dac_din, cyc);
      end else begin
        mon_w = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (dac_din !== mon_w) begin
          failures++;
          $display("FAIL issue_word: got %h, required %h (cycle %0d)", dac_din, mon_w, cyc);
        end
        checks++;
        if (cyc != mon_c) begin
          failures++;
          $display("FAIL issue_cycle: got %0d, required %0d (word %h)", cyc, mon_c, mon_w);
        end
        last_word = mon_w;
      end
    end else begin
      checks++;
      if (dac_din !== last_word) begin
        failures++;
        $display("FAIL din_stable: got %h, required %h (cycle %0d)", dac_din, last_word, cyc);
      end
    end
`ifdef DAC_SCHEDULER_LDAC_EN
    if (!rst && ldac) begin
      checks++;
      if (ldac_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ldac: got pulse at cycle %0d, required none", cyc);
      end else begin
        mon_c = ldac_q.pop_front();
        if (cyc != mon_c) begin
          failures++;
          $display("FAIL ldac_cycle: got %0d, required %0d", cyc, mon_c);
        end
      end
    end
`endif
  end

  // stimulus
  initial begin
    rst      = 1'b1;
    wr_en_in = 1'b0;
    wr_ch    = 2'd0;
    wr_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_din",     32'(dac_din),     32'h0);
    check("rst_wr_en",   32'(dac_wr_en),   32'h0);
    check("rst_pending", 32'(pending),     32'h0);
    check("rst_busy",    32'(busy),        32'h0);
    check("rst_state",   32'(o_state_dbg), 32'h0);
    rst = 1'b0;

    // single write, latency and frame length
    expect_issue(16'h101B, 12);
`ifdef DAC_SCHEDULER_LDAC_EN
    ldac_q.push_back(53);
`endif
    write_at(10, 2'd1, 12'h01B);
    check("a_pending_set", 32'(pending), 32'h2);
    check("a_busy_set",    32'(busy),    32'h1);
    goto_cycle(13);
    check("a_pending_clr", 32'(pending), 32'h0);
    goto_cycle(52);
    check("a_busy_last_wait", 32'(busy), 32'h1);
    goto_cycle(53);
    check("a_busy_low", 32'(busy), 32'h0);
    check("a_state_idle", 32'(o_state_dbg), 32'h0);

    // round-robin order: ch3 frame, three writes queued during its wait
    expect_issue(16'h3777, 62);
    expect_issue(16'h0555, 104);
    expect_issue(16'h2AAA, 146);
    expect_issue(16'h30F0, 188);
`ifdef DAC_SCHEDULER_LDAC_EN
    ldac_q.push_back(229);
`endif
    write_at(60, 2'd3, 12'h777);
    write_at(70, 2'd2, 12'hAAA);
    write_at(71, 2'd0, 12'h555);
    write_at(72, 2'd3, 12'h0F0);
    check("b_pending_three", 32'(pending), 32'hD);
    goto_cycle(228);
    check("b_busy_last_wait", 32'(busy), 32'h1);
    goto_cycle(229);
    check("b_busy_low", 32'(busy), 32'h0);

    // coalescing: two writes to ch1 while ch2 frame runs
    expect_issue(16'h2001, 242);
    expect_issue(16'h1200, 284);
`ifdef DAC_SCHEDULER_LDAC_EN
    ldac_q.push_back(325);
`endif
    write_at(240, 2'd2, 12'h001);
    write_at(250, 2'd1, 12'h100);
    write_at(251, 2'd1, 12'h200);
    check("c_pending_one", 32'(pending), 32'h2);

    // write in the ISSUE cycle of the same channel
    expect_issue(16'h0111, 342);
    expect_issue(16'h0123, 384);
`ifdef DAC_SCHEDULER_LDAC_EN
    ldac_q.push_back(425);
`endif
    write_at(340, 2'd0, 12'h111);
    write_at(342, 2'd0, 12'h123);
    check("d_pending_kept", 32'(pending), 32'h1);

    // reset in the middle of a frame with ch3 pending
    expect_issue(16'h10AB, 442);
    write_at(440, 2'd1, 12'h0AB);
    write_at(450, 2'd3, 12'h0CD);
    goto_cycle(462);
    check("e_pending_ch3", 32'(pending), 32'h8);
    check("e_busy_wait",   32'(busy),    32'h1);
    rst = 1'b1;
    #1;
    check("e_rst_din",     32'(dac_din),     32'h0);
    check("e_rst_wr_en",   32'(dac_wr_en),   32'h0);
    check("e_rst_pending", 32'(pending),     32'h0);
    check("e_rst_busy",    32'(busy),        32'h0);
    check("e_rst_state",   32'(o_state_dbg), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    goto_cycle(150);
    check("e_idle_after_rst", 32'(busy), 32'h0);

    check("all_issues_seen", 32'(exp_q.size()), 32'h0);
`ifdef DAC_SCHEDULER_LDAC_EN
    check("all_ldac_seen", 32'(ldac_q.size()), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
